if_stage: RTL and testbench

Instruction fetch stage for the Radix-CPU pipeline: the producer side of the instruction word consumed by decode. Keeps the fetch PC and issues in-order word requests to instruction memory. Buffers responses in a small FIFO and presents `{pc, instr}` to the decode stage with a valid/ready handshake. A redirect (branch/jump resolved downstream) flushes buffered words and discards responses still in flight.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/if_stage_fetch_fifo.sv | 76 +++++++
 rtl/if_stage.sv | 165 ++++++++++++++++
 tb/tb_if_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared Radix-CPU pipeline types: machine width, the canonical NOP,
// fetch FSM encoding and the {pc, instr} word handed from fetch to decode.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Value the decode-facing head shows out of reset.
    localparam fetch_entry_t FETCH_ENTRY_RESET = '{pc: '0, instr: NOP_INSTR};

    // Instruction addresses are word aligned; the low two bits carry no meaning.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small shift-register FIFO for fetched words. Entry 0 is always the head,
// so the consumer-facing outputs come straight from a register with no
// read-pointer mux. Clear wins over a same-cycle push and pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int     DEPTH       = 2,
    parameter type    entry_t     = fetch_entry_t,
    parameter entry_t RESET_ENTRY = FETCH_ENTRY_RESET,
    localparam int    CNT_W       = $clog2(DEPTH + 1),
    localparam int    IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             pop_ok;
    logic             push_ok;

    // Next contents: shift down on pop, then write the push at the first free slot.
    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        overflow = 1'b0;
        pop_ok   = pop && (count_q != '0);
        wr_idx   = count_q - CNT_W'(pop_ok);
        push_ok  = push && (int'(wr_idx) < DEPTH);
        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        if (push_ok) begin
            mem_d[wr_idx[IDX_W-1:0]] = push_data;
        end
        overflow = push && !push_ok;
        count_d  = wr_idx + CNT_W'(push_ok);
        if (clear) begin
            count_d  = '0;
            overflow = 1'b0;
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_ENTRY;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            count_q <= count_d;
        end
    end

    assign head       = mem_q[0];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage. Issues in-order word requests from fetch_pc,
// tags returning words with rsp_pc and buffers them for decode. A redirect
// restarts both PCs at the target, empties the buffer and turns every
// request still in flight into a response that must be discarded.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Valid never depends combinationally on the matching ready. imem responses
// are never back-pressured and return in request order.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2,
    localparam int             CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_instr,
    output logic [XLEN-1:0]  id_pc,
    output fetch_state_t     dbg_state,
    output logic [CNT_W-1:0] dbg_outstanding,
    output logic [CNT_W-1:0] dbg_drop_cnt,
    output logic [CNT_W-1:0] dbg_fifo_count,
    output logic             dbg_overflow
);

    localparam int SUM_W = CNT_W + 2;

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [XLEN-1:0]  fetch_pc_q;
    logic [XLEN-1:0]  fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q;
    logic [XLEN-1:0]  rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;
    logic [CNT_W-1:0] fifo_count;
    logic [SUM_W-1:0] credit_used;
    logic             req_fire;
    logic             rsp_live;
    logic             rsp_drop;
    logic             fifo_push;
    logic             fifo_valid;
    logic             fifo_overflow;
    fetch_entry_t     push_entry;
    fetch_entry_t     fifo_head;

    // Every request, stale or live, holds a credit until its response is
    // consumed or dropped, so a live response always finds a free slot.
    assign credit_used = SUM_W'(outstanding_q) + SUM_W'(drop_cnt_q) + SUM_W'(fifo_count);

    assign imem_req_valid = (state_q != IDLE) && fetch_en && !redirect
                            && (credit_used < SUM_W'(DEPTH));
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses are in order, so all stale ones arrive before any live one.
    assign rsp_drop   = imem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_live   = imem_rsp_valid && (drop_cnt_q == '0);
    assign fifo_push  = rsp_live && !redirect;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    // PC and credit counter updates; a redirect overrides normal bookkeeping.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect) begin
            fetch_pc_d    = word_align(redirect_pc);
            rsp_pc_d      = word_align(redirect_pc);
            outstanding_d = '0;
            // The response arriving right now is one of the stale ones and is
            // dropped immediately, hence the minus one.
            drop_cnt_d    = drop_cnt_q + outstanding_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_live) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    // Next-state logic: FLUSH lasts exactly as long as stale responses remain.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            if (drop_cnt_d != '0) begin
                state_d = FLUSH;
            end else begin
                state_d = fetch_en ? RUN : IDLE;
            end
        end else begin
            case (state_q)
                IDLE:    if (fetch_en) state_d = RUN;
                RUN:     if (!fetch_en) state_d = IDLE;
                FLUSH:   if (drop_cnt_d == '0) state_d = fetch_en ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, PC and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH      (DEPTH),
        .entry_t    (fetch_entry_t),
        .RESET_ENTRY(FETCH_ENTRY_RESET)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (id_ready),
        .head      (fifo_head),
        .head_valid(fifo_valid),
        .count     (fifo_count),
        .overflow  (fifo_overflow)
    );

    assign id_valid = fifo_valid;
    assign id_pc    = fifo_head.pc;
    assign id_instr = fifo_head.instr;

    assign dbg_state       = state_q;
    assign dbg_outstanding = outstanding_q;
    assign dbg_drop_cnt    = drop_cnt_q;
    assign dbg_fifo_count  = fifo_count;
    assign dbg_overflow    = fifo_overflow;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model with random latency, queue-based model of
// the delivered word stream, directed scenarios plus a random soak.
module tb_if_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;
    localparam int          CNT_W    = $clog2(DEPTH + 1);

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             fetch_en = 1'b0;
    logic             redirect = 1'b0;
    logic [31:0]      redirect_pc = '0;
    logic             imem_req_valid;
    logic             imem_req_ready = 1'b0;
    logic [31:0]      imem_addr;
    logic             imem_rsp_valid = 1'b0;
    logic [31:0]      imem_rsp_data = '0;
    logic             id_valid;
    logic             id_ready = 1'b0;
    logic [31:0]      id_instr;
    logic [31:0]      id_pc;
    fetch_state_t     dbg_state;
    logic [CNT_W-1:0] dbg_outstanding;
    logic [CNT_W-1:0] dbg_drop_cnt;
    logic [CNT_W-1:0] dbg_fifo_count;
    logic             dbg_overflow;

    if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .dbg_state(dbg_state), .dbg_outstanding(dbg_outstanding),
        .dbg_drop_cnt(dbg_drop_cnt), .dbg_fifo_count(dbg_fifo_count),
        .dbg_overflow(dbg_overflow)
    );

    // ---------------- model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mem_q[$];     // accepted requests, in order, until answered
    logic [63:0] exp_q[$];     // expected decode stream {pc, instr}
    logic [31:0] dlv_q[$];     // pcs decode actually took (outside redirect cycles)
    logic [31:0] m_fetch_pc;
    bit          m_active;
    bit          exp_req;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // stimulus knobs
    bit          k_rst = 1'b1;
    bit          k_fetch_en = 1'b0;
    int          k_req_pct = 100;
    int          k_id_pct = 100;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          rd_req = 1'b0;
    logic [31:0] rd_target = '0;
    bit          k_rd_on_rsp = 1'b0;
    bit          hit_combo = 1'b0;
    int          rel_cyc = 0;
    int          first_valid = -1;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].stale) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- compare against the model ----------------
    task automatic compare_outputs();
        fetch_state_t e_state;
        int           st;
        if (rst) begin
            exp_req = 1'b0;
            check("rst_req_valid", imem_req_valid, 0);
            check("rst_imem_addr", imem_addr, RESET_PC);
            check("rst_id_valid", id_valid, 0);
            check("rst_id_instr", id_instr, NOP_INSTR);
            check("rst_id_pc", id_pc, 0);
            check("rst_state", dbg_state, IDLE);
            check("rst_counts", {dbg_outstanding, dbg_drop_cnt, dbg_fifo_count}, 0);
        end else begin
            st      = stale_cnt();
            exp_req = m_active && fetch_en && !redirect && (mem_q.size() + exp_q.size() < DEPTH);
            e_state = !m_active ? IDLE : ((st > 0) ? FLUSH : RUN);
            check("req_valid", imem_req_valid, exp_req);
            check("imem_addr", imem_addr, m_fetch_pc);
            check("id_valid", id_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("id_pc", id_pc, exp_q[0][63:32]);
                check("id_instr", id_instr, exp_q[0][31:0]);
            end
            check("state", dbg_state, e_state);
            check("drop_cnt", dbg_drop_cnt, st);
            check("outstanding", dbg_outstanding, mem_q.size() - st);
            check("fifo_count", dbg_fifo_count, exp_q.size());
            check("overflow", dbg_overflow, 0);
            if (id_valid && first_valid < 0) first_valid = cyc - rel_cyc;
        end
    endtask

    // ---------------- one clock cycle: drive, compare, advance model ----------------
    task automatic cycle();
        bit          s_rst, s_fe, s_rd, s_req, s_rdy, s_rsp, s_idr;
        logic [31:0] s_rpc;
        mreq_t       r;
        @(negedge clk);
        rst            = k_rst;
        fetch_en       = k_fetch_en;
        imem_req_ready = ($urandom_range(99) < k_req_pct);
        id_ready       = ($urandom_range(99) < k_id_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if (k_rd_on_rsp && imem_rsp_valid && id_ready && exp_q.size() > 0 && !k_rst) begin
            rd_req      = 1'b1;
            rd_target   = 32'h0000_3000;
            k_rd_on_rsp = 1'b0;
            hit_combo   = 1'b1;
        end
        redirect    = rd_req && !k_rst;
        redirect_pc = rd_req ? rd_target : $urandom;
        rd_req      = 1'b0;
        #1;
        compare_outputs();
        if (!rst && !redirect && id_valid && id_ready) dlv_q.push_back(id_pc);
        s_rst = rst; s_fe = fetch_en; s_rd = redirect; s_rpc = redirect_pc;
        s_req = exp_req; s_rdy = imem_req_ready; s_rsp = imem_rsp_valid; s_idr = id_ready;
        @(posedge clk);
        if (s_rst) begin
            mem_q.delete();
            exp_q.delete();
            m_fetch_pc = RESET_PC;
            m_active   = 1'b0;
        end else begin
            if (s_idr && exp_q.size() > 0) void'(exp_q.pop_front());
            if (s_rsp && mem_q.size() > 0) begin
                r = mem_q.pop_front();
                if (!r.stale) exp_q.push_back({r.addr, word_of(r.addr)});
            end
            if (exp_q.size() > DEPTH) check("model_overflow", exp_q.size(), DEPTH);
            if (s_rd) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                m_fetch_pc = {s_rpc[31:2], 2'b00};
            end else if (s_req && s_rdy) begin
                mem_q.push_back('{addr: m_fetch_pc, due: cyc + $urandom_range(lat_hi, lat_lo), stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            m_active = s_fe || (stale_cnt() > 0);
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // waits until the model shows two live requests in flight, bounded
    task automatic wait_two_live(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            cycle();
            ok = (mem_q.size() - stale_cnt() == 2);
        end
        check(name, ok, 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n0;
        bit ok;
        m_fetch_pc = RESET_PC;
        m_active   = 1'b0;

        // reset
        k_rst = 1'b1;
        run(3);

        // basic stream: 1-cycle memory, decode always ready
        k_rst = 1'b0; k_fetch_en = 1'b1; k_req_pct = 100; k_id_pct = 100;
        lat_lo = 1; lat_hi = 1;
        dlv_q.delete();
        rel_cyc = cyc;
        first_valid = -1;
        run(14);
        check("first_valid_latency", first_valid, 3);
        check("stream_pc0", dlv_q[0], 32'h0000_0100);
        check("stream_pc1", dlv_q[1], 32'h0000_0104);
        check("stream_pc2", dlv_q[2], 32'h0000_0108);

        // back-pressure: decode stalls for 10 cycles
        k_id_pct = 0;
        run(10);
        #1;
        check("bp_fifo_full", dbg_fifo_count, 2);
        check("bp_req_blocked", imem_req_valid, 0);
        check("bp_id_valid", id_valid, 1);
        k_id_pct = 100;
        run(10);

        // redirect with two requests in flight
        lat_lo = 3; lat_hi = 3;
        wait_two_live("wait_two_live_redirect");
        rd_req = 1'b1; rd_target = 32'h0000_2002;
        n0 = dlv_q.size();
        run(20);
        check("redirect_first_pc", (dlv_q.size() > n0) ? dlv_q[n0] : 32'hDEAD_BEEF, 32'h0000_2000);

        // redirect landing together with a response and a decode pop
        lat_lo = 1; lat_hi = 2; k_id_pct = 70; k_req_pct = 80;
        hit_combo = 1'b0; k_rd_on_rsp = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            cycle();
            ok = hit_combo;
        end
        check("combo_reached", ok, 1);
        #1;
        check("combo_fifo_empty", dbg_fifo_count, 0);
        check("combo_addr", imem_addr, 32'h0000_3000);
        k_rd_on_rsp = 1'b0;
        run(10);

        // wrap at the top of the address space
        k_id_pct = 100; k_req_pct = 100; lat_lo = 1; lat_hi = 1;
        run(5);
        rd_req = 1'b1; rd_target = 32'hFFFF_FFFE;
        n0 = dlv_q.size();
        run(15);
        check("wrap_pc0", (dlv_q.size() > n0) ? dlv_q[n0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_pc1", (dlv_q.size() > n0 + 1) ? dlv_q[n0 + 1] : 32'hDEAD_BEEF, 32'h0000_0000);

        // fetch_en drops with two requests outstanding
        lat_lo = 3; lat_hi = 3;
        wait_two_live("wait_two_live_fetch_off");
        k_fetch_en = 1'b0;
        n0 = dlv_q.size();
        run(10);
        #1;
        check("off_delivered", dlv_q.size() - n0, 2);
        check("off_state_idle", dbg_state, IDLE);
        check("off_req_valid", imem_req_valid, 0);
        check("off_id_valid", id_valid, 0);

        // random soak
        k_fetch_en = 1'b1; k_req_pct = 70; k_id_pct = 60; lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3) k_fetch_en = !k_fetch_en;
            if ($urandom_range(99) < 4) begin
                rd_req    = 1'b1;
                rd_target = ($urandom_range(4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            end
            cycle();
        end

        // asynchronous reset in the middle of traffic
        k_fetch_en = 1'b1;
        run(20);
        k_rst = 1'b1;
        run(2);
        k_rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(99) < 4) begin
                rd_req = 1'b1; rd_target = $urandom;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
